// File: rtl/injection_pkg.sv
// Shared types and constants for the injection_core slice.
// Holds the FSM state encoding, counter width and default hold length.
package injection_pkg;

    localparam int CNT_W           = 8;
    localparam int HOLD_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        INJECT = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/injection_core_edge_detect.sv
// Rising-edge detector: delays the input one cycle and flags 0->1.
// The pulse is one cycle wide and aligned to the undelayed input.
module edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/injection_core.sv
// Fault-injection leaf: registered majority/AND function on y1 and a
// data path on y2 that a small FSM inverts for HOLD_CYCLES edges.
module injection_core
    import injection_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    output logic y1,
    output logic y2
);

    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic r_a;
    logic r_b;
    logic r_c;
    logic r_d;
    logic r_e;
    logic r_f;
    logic r_y1;
    logic r_y2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_trig;
    logic w_inject;
    logic w_maj;
    logic w_base2;

    // Input sampling stage
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_a <= 1'b0;
            r_b <= 1'b0;
            r_c <= 1'b0;
            r_d <= 1'b0;
            r_e <= 1'b0;
            r_f <= 1'b0;
        end else begin
            r_a <= a;
            r_b <= b;
            r_c <= c;
            r_d <= d;
            r_e <= e;
            r_f <= f;
        end
    end

    // Trigger is a rising edge on the sampled b
    edge_detect u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (r_b),
        .o_rise (w_trig)
    );

    // FSM state and window counter registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; disarm wins over a same-cycle trigger
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (r_e) begin
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!r_e) begin
                    w_state_nxt = IDLE;
                end else if (w_trig) begin
                    w_state_nxt = INJECT;
                    w_cnt_nxt   = LP_CNT_LOAD;
                end
            end
            INJECT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            HOLD: begin
                if (!r_b) begin
                    w_state_nxt = r_e ? ARMED : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM output: invert y2 while injecting
    always_comb begin
        w_inject = (r_state == INJECT);
    end

    assign w_maj   = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);
    assign w_base2 = (r_c | r_f) & ~r_a;

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_y1 <= 1'b0;
            r_y2 <= 1'b0;
        end else begin
            r_y1 <= w_maj ^ (r_d & r_e);
            r_y2 <= w_base2 ^ w_inject;
        end
    end

    assign y1 = r_y1;
    assign y2 = r_y2;

endmodule

// File: tb/tb_injection_core.sv
// Self-checking bench for injection_core with a cycle model
// feeding an expectation queue that is drained after each edge.
module tb_injection_core;

    logic clk;
    logic rstn;
    logic a, b, c, d, e, f;
    logic y1, y2;

    int n_run;
    int n_fail;
    int cyc;

    typedef struct {
        int         due;
        logic       y1;
        logic       y2;
        logic [1:0] st;
    } exp_t;

    exp_t q[$];

    // reference model state
    logic m_a, m_b, m_c, m_d, m_e, m_f, m_bqq;
    logic m_y1, m_y2;
    int   m_st;
    int   m_left;

    injection_core #(.HOLD_CYCLES(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .e    (e),
        .f    (f),
        .y1   (y1),
        .y2   (y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d",
                     tag, cyc, obs, exp);
        end
    endtask

    // advance the model by one rising edge using vector v
    task automatic model_edge(input logic r, input logic [5:0] v);
        logic nmaj, trig;
        int   ns;
        if (!r) begin
            {m_a, m_b, m_c, m_d, m_e, m_f, m_bqq} = '0;
            m_st = 0; m_left = 0; m_y1 = 0; m_y2 = 0;
        end else begin
            nmaj = (m_a + m_b + m_c) >= 2;
            m_y1 = nmaj ^ (m_d & m_e);
            m_y2 = ((m_c | m_f) & ~m_a) ^ (m_st == 2);
            trig = m_b & ~m_bqq;
            ns = m_st;
            if (m_st == 0) begin
                if (m_e) ns = 1;
            end else if (m_st == 1) begin
                if (!m_e) ns = 0;
                else if (trig) begin ns = 2; m_left = 2; end
            end else if (m_st == 2) begin
                m_left--;
                if (m_left == 0) ns = 3;
            end else begin
                if (!m_b) ns = m_e ? 1 : 0;
            end
            m_st  = ns;
            m_bqq = m_b;
            {m_a, m_b, m_c, m_d, m_e, m_f} = v;
        end
    endtask

    // v = {a,b,c,d,e,f}
    task automatic drive(input logic r, input logic [5:0] v,
                         input int n);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rstn = r;
            {a, b, c, d, e, f} = v;
            model_edge(r, v);
            x.due = cyc + 1;
            x.y1  = m_y1;
            x.y2  = m_y2;
            x.st  = 2'(m_st);
            q.push_back(x);
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due == cyc) begin
                x = q.pop_front();
                chk("y1", {7'd0, y1}, {7'd0, x.y1});
                chk("y2", {7'd0, y2}, {7'd0, x.y2});
                chk("state", {6'd0, 2'(dut.r_state)}, {6'd0, x.st});
            end
        end
    endtask

    initial begin
        n_run = 0; n_fail = 0; cyc = 0;
        rstn = 1'b0;
        {a, b, c, d, e, f} = '0;
        {m_a, m_b, m_c, m_d, m_e, m_f, m_bqq} = '0;
        m_st = 0; m_left = 0; m_y1 = 0; m_y2 = 0;

        // reset with all inputs high, then release
        drive(1'b0, 6'b111111, 3);
        drive(1'b1, 6'b111111, 3);

        // y1 function
        drive(1'b1, 6'b110000, 3);
        drive(1'b1, 6'b110110, 3);
        drive(1'b1, 6'b010110, 3);

        // y2 base, e low, b toggling
        drive(1'b1, 6'b001000, 3);
        drive(1'b1, 6'b101000, 3);
        drive(1'b1, 6'b000001, 3);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 6'b010001, 2);
            drive(1'b1, 6'b000001, 1);
        end

        // two injections
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010011, 6);
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010011, 4);
        drive(1'b1, 6'b000011, 3);

        // disarm in the trigger cycle
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010001, 3);
        drive(1'b1, 6'b000001, 2);

        // e drops during INJECT
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010011, 1);
        drive(1'b1, 6'b010001, 5);
        drive(1'b1, 6'b000001, 3);

        // reset at first INJECT cycle
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010011, 2);
        drive(1'b0, 6'b010011, 1);
        drive(1'b1, 6'b000011, 3);
        drive(1'b1, 6'b010011, 5);
        drive(1'b1, 6'b000011, 3);

        if (q.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL queue_drain left=%0d want=0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/injection_core.md
Name: injection_core

Overview:
- Small fault-injection validation block: six single-bit control/data inputs, two registered outputs.
- y1 is a registered combinational function of the inputs.
- y2 is a registered data path that a 4-state injection FSM inverts for a bounded window.
- Used as a leaf target for injection/validation experiments; no bus interface.

Parameters:
- HOLD_CYCLES, 2, number of consecutive cycles y2 is inverted per injection event (legal range 1..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- a  input  1  data; majority term of y1; masks y2 base.
- b  input  1  data; majority term of y1; its rising edge is the injection trigger.
- c  input  1  data; majority term of y1; OR term of y2 base.
- d  input  1  data; AND term with e for y1.
- e  input  1  data for y1; also the arm enable for the injection FSM.
- f  input  1  data; OR term of y2 base.
- y1  output  1  registered result, see Behaviour.
- y2  output  1  registered result, possibly inverted by the FSM.

Behaviour:
- Reset: while rstn=0 at a rising edge, the following clear:
  - all input registers a_q..f_q and b_qq go to 0;
  - state goes to IDLE and the counter to 0;
  - y1=0 and y2=0.
  - Reset overrides everything, including mid-INJECT.
- Input stage: every edge a_q..f_q <= a..f, and b_qq <= b_q.
  - Inputs are sampled only at rising edges; stimulus must change away from edges.
- Output latency: 2 edges from an input change to the output (edge N samples, edge N+1 drives the output).
- y1 <= maj(a_q,b_q,c_q) XOR (d_q AND e_q), where maj = (a&b)|(a&c)|(b&c).
- base2 = (c_q OR f_q) AND NOT a_q.
- y2 <= base2 XOR (state==INJECT).
- trig = b_q AND NOT b_qq (one-cycle rising-edge pulse).
- FSM states IDLE, ARMED, INJECT, HOLD; 2-bit encoding 0..3 in that order.
- IDLE: e_q=1 goes to ARMED; otherwise stay.
- ARMED:
  - e_q=0 goes to IDLE; this has priority over trig.
  - Otherwise trig=1 goes to INJECT and loads cnt = HOLD_CYCLES-1.
  - Otherwise stay.
- INJECT:
  - cnt==0 goes to HOLD; otherwise cnt <= cnt-1.
  - e_q is ignored: dropping e does not abort an injection.
- HOLD:
  - b_q=0 goes to ARMED if e_q=1, else IDLE.
  - Otherwise stay. No retrigger is possible while b is held high.
- Timing: INJECT occupies exactly HOLD_CYCLES cycles, so y2 is inverted for exactly HOLD_CYCLES consecutive edges.
  - For a b rising edge sampled at edge k, the first inverted y2 appears at edge k+2.
- A trig pulse seen in IDLE or in the same cycle as arming is ignored; there is no queuing.
- cnt width is 8 bits; it is only meaningful in INJECT.
- No X propagation: every register has a reset value and every state has a defined next state.

Decomposition:
- Shared package injection_pkg holds:
  - state typedef (IDLE, ARMED, INJECT, HOLD);
  - HOLD_CYCLES default;
  - CNT_W=8.
- One natural sub-module: edge_detect (register plus AND-NOT), producing trig from b.
- Everything else lives in injection_core.

Test Plan:
- Reset: hold rstn=0 for 3 edges with a..f=1 -> y1=0, y2=0 throughout. Release -> 2 edges later y1=maj(1,1,1)^(1&1)=0 and y2=(1|1)&~1=0; state is ARMED after the release edges.
- y1 function: a=1,b=1,c=0,d=0,e=0 -> y1=1 two edges later. Then d=1,e=1 -> y1=0. Then a=0 -> y1=1 (maj=0, XOR 1).
- y2 base: a=0,c=1,f=0 -> y2=1. Then a=1 -> y2=0. Then a=0,c=0,f=1 -> y2=1. With e=0 no inversion ever occurs, even while b toggles.
- Injection: e=1, a=0, f=1 steady (y2=1), then b 0->1 held 6 cycles -> y2=0 for exactly 2 edges (HOLD_CYCLES=2), then y2=1. State stays HOLD until b=0, then returns to ARMED. A second b pulse gives a second 2-cycle dip.
- Disarm/priority: e drops while ARMED in the same cycle b rises -> IDLE, no dip. e drops during INJECT -> dip still completes its 2 cycles, then HOLD, then IDLE after b=0.
- Reset mid-operation: rstn=0 at the first INJECT cycle -> next edge y2=0, state IDLE, cnt=0. After release with e=1, a fresh b rising edge produces a full HOLD_CYCLES dip.
